// File: rtl/duty_clk_gen_if.sv
// rtl/duty_clk_gen_if.sv - config/status bundle for duty_clk_gen.
// DUTY_CLK_PERIOD_CNT_EN adds the period_cnt status field.
interface duty_clk_gen_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             clk_out;
  logic             period_start;
  logic             cfg_err;
`ifdef DUTY_CLK_PERIOD_CNT_EN
  logic [15:0]      period_cnt;

  modport master (
    output en, period, high_cnt,
    input  clk_out, period_start, cfg_err, period_cnt
  );
  modport slave (
    input  en, period, high_cnt,
    output clk_out, period_start, cfg_err, period_cnt
  );
`else
  modport master (
    output en, period, high_cnt,
    input  clk_out, period_start, cfg_err
  );
  modport slave (
    input  en, period, high_cnt,
    output clk_out, period_start, cfg_err
  );
`endif
endinterface

// File: rtl/duty_clk_gen.sv
// rtl/duty_clk_gen.sv - programmable-duty clock-enable generator (IDLE/RUN counter FSM).
// DUTY_CLK_PERIOD_CNT_EN adds a wrapping 16-bit count of completed periods.
module duty_clk_gen #(
  parameter int CNT_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  duty_clk_gen_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] w_h_nxt;
  logic             r_clk_out;
  logic             w_clk_out_nxt;
  logic             r_period_start;
  logic             w_period_start_nxt;
  logic             r_cfg_err;
  logic             w_cfg_err_nxt;

  logic             w_cfg_ok;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cfg_ok  = (bus.period != '0) && (bus.high_cnt <= bus.period);
  // Shadow N is never 0 in RUN, so N_s-1 cannot underflow there.
  assign w_last    = (r_cnt == (r_n - CNT_W'(1)));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_n            <= '0;
      r_h            <= '0;
      r_clk_out      <= 1'b0;
      r_period_start <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_n            <= w_n_nxt;
      r_h            <= w_h_nxt;
      r_clk_out      <= w_clk_out_nxt;
      r_period_start <= w_period_start_nxt;
      r_cfg_err      <= w_cfg_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_n_nxt            = r_n;
    w_h_nxt            = r_h;
    w_clk_out_nxt      = 1'b0;
    w_period_start_nxt = 1'b0;
    w_cfg_err_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.en) begin
          if (w_cfg_ok) begin
            w_n_nxt            = bus.period;
            w_h_nxt            = bus.high_cnt;
            w_state_nxt        = ST_RUN;
            w_period_start_nxt = 1'b1;
            w_clk_out_nxt      = (bus.high_cnt != '0);
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!w_last) begin
          w_cnt_nxt     = w_cnt_inc;
          w_clk_out_nxt = (w_cnt_inc < r_h);
        end else begin
          w_cnt_nxt = '0;
          if (!bus.en) begin
            w_state_nxt = ST_IDLE;
          end else if (w_cfg_ok) begin
            w_n_nxt            = bus.period;
            w_h_nxt            = bus.high_cnt;
            w_period_start_nxt = 1'b1;
            w_clk_out_nxt      = (bus.high_cnt != '0);
          end else begin
            // Bad config at the boundary: repeat the old period and flag it.
            w_period_start_nxt = 1'b1;
            w_clk_out_nxt      = (r_h != '0);
            w_cfg_err_nxt      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.clk_out      = r_clk_out;
  assign bus.period_start = r_period_start;
  assign bus.cfg_err      = r_cfg_err;

`ifdef DUTY_CLK_PERIOD_CNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period_cnt <= '0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign bus.period_cnt = r_period_cnt;
`endif

endmodule
